x86_sram_bridge: RTL and testbench
==================================

# x86_sram_bridge

Memory responder for the x86cpu byte bus. It accepts the CPU's 20-bit byte address with `rd`/`wr` strobes and serves each access from an external 16-bit asynchronous SRAM, with a programmable wait-state count. It returns read bytes on `i_data` and drives the CPU's `locked` enable high for exactly one cycle per completed bus cycle. It sits between x86cpu and the board SRAM pins; the CPU advances only on cycles where `locked` is high.

## Interface
- `WAIT`, default 2: SRAM access cycles per transfer; legal range 1..15.
- `SRAM_AW`, default 18: SRAM word-address width. Capacity is 2^(SRAM_AW+1) bytes.
- `clock` in 1: system clock, 12.5 MHz.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `address` in 20: CPU byte address.
- `o_data` in 8: CPU write data.
- `rd` in 1: CPU read request.
- `wr` in 1: CPU write request. If `rd` and `wr` are both high, `wr` wins.
- `i_data` out 8: read byte returned to the CPU.
- `locked` out 1: one-cycle completion pulse; this is the CPU's enable.
- `sram_addr` out SRAM_AW: SRAM word address, = `address[SRAM_AW:1]`.
- `sram_din` in 16: data read from the SRAM pins.
- `sram_dout` out 16: data driven to the SRAM pins.
- `sram_dq_oe` out 1: tristate enable for `sram_dout`.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_lb_n`, `sram_ub_n` out 1 each: active-low SRAM controls.

## Operation
- **FSM states:** IDLE, ACCESS, DONE.
- **IDLE:**
  - Registers `address`, `o_data` and the operation: WRITE, READ or NOP, with `wr` taking priority over `rd`.
  - READ or WRITE goes to ACCESS and loads the wait counter with `WAIT-1`.
  - NOP goes to DONE.
  - Out-of-range address (`address[19:SRAM_AW+1]` not all zero) goes to DONE. A read sets `i_data` to 8'hFF; a write is dropped.
- **Byte lanes:**
  - `address[0]=0` selects the low lane: `sram_lb_n=0`, read byte = `sram_din[7:0]`.
  - `address[0]=1` selects the high lane: `sram_ub_n=0`, read byte = `sram_din[15:8]`.
  - The unused lane strobe stays 1.
- **ACCESS, read:** `ce_n=0`, `oe_n=0`, `we_n=1`, `sram_dq_oe=0`.
- **ACCESS, write:** `ce_n=0`, `oe_n=1`, `we_n=0`, `sram_dq_oe=1`, `sram_dout={o_data,o_data}`.
- **ACCESS, countdown:** the counter decrements each cycle. At zero, a read latches the selected byte into `i_data` and the FSM goes to DONE.
- **DONE:**
  - `locked=1`.
  - All SRAM strobes inactive (`we_n=1`, `oe_n=1`, `ce_n=1`).
  - `sram_addr`, `sram_dout` and `sram_dq_oe` keep their values for write hold time.
  - Next state is IDLE.
- `i_data` holds its value until the next read completes.
- Each registered request produces exactly one `locked` pulse, and `locked` is never high for two consecutive cycles.

## Timing
- **Reset values:** `locked=0`, `i_data=8'hFF`, `sram_ce_n=1`, `sram_oe_n=1`, `sram_we_n=1`, `sram_lb_n=1`, `sram_ub_n=1`, `sram_dq_oe=0`, `sram_addr=0`, `sram_dout=0`, state IDLE.
- **Latency** (edge T = request sampled in IDLE):
  - READ/WRITE: `locked` high in cycle T+WAIT+1.
  - NOP and out-of-range: `locked` high in cycle T+1.
- **Handshake:**
  - The CPU changes `address`/`rd`/`wr`/`o_data` only at the edge where `locked=1`.
  - The bridge samples the next request at the following edge, in IDLE.
  - Back-to-back reads therefore cost WAIT+2 cycles each.
- **Write timing:** `we_n` is low for exactly WAIT cycles. Address and data are stable one cycle before `we_n` falls and one cycle after it rises.
- **Reset mid-operation:** the next edge forces the reset values. `we_n` returns high and no `locked` pulse is emitted for the aborted request.
- **`WAIT` out of range:** values outside 1..15 are a configuration error, caught by an elaboration check.

## Structure
- Shared include `busdefs.v` holds:
  - state encodings (`bst_idle`, `bst_access`, `bst_done`);
  - operation codes (NOP/READ/WRITE);
  - the out-of-range read value 8'hFF.
- Single flat module; no sub-module. The lane mux and lane strobes are a few lines of combinational logic.

## Test plan
- Word 0x00000 of the SRAM model = 16'hA55A, WAIT=2: read 0x00000 -> `i_data`=8'h5A with `locked` in cycle T+3; read 0x00001 -> 8'hA5.
- Write 8'h3C to 0x00101 -> `sram_addr`=0x00080, `ub_n`=0, `lb_n`=1, `sram_dout`=16'h3C3C, `we_n` low for 2 cycles; model word becomes 16'h3Cxx with the low byte unchanged.
- Read 0xF0000 with SRAM_AW=18 -> no SRAM strobe, `i_data`=8'hFF, `locked` in T+1. Write 0xF0000 -> dropped, `we_n` stays 1.
- `rd`=`wr`=1 at 0x00002 with `o_data`=8'h11 -> write performed; `i_data` unchanged.
- Assert `reset` in the second ACCESS cycle of a write -> `we_n`=1 and `locked`=0 the next cycle; all outputs at reset values.
- 8 back-to-back reads driven by a CPU model that advances only on `locked` -> exactly 8 single-cycle `locked` pulses spaced WAIT+2 cycles apart, with correct bytes. Repeat with WAIT=1 and WAIT=15.

Source files
------------

// File: rtl/x86_sram_bridge_pkg.sv
// Shared encodings for the x86 byte-bus to asynchronous SRAM bridge:
// FSM states, bus operation codes and the value returned for unmapped reads.
package x86_sram_bridge_pkg;

  typedef enum logic [1:0] {
    BST_IDLE   = 2'd0,
    BST_ACCESS = 2'd1,
    BST_DONE   = 2'd2
  } bst_t;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_t;

  localparam logic [7:0] OOR_READ_VAL = 8'hFF;
  localparam int         WAIT_MIN     = 1;
  localparam int         WAIT_MAX     = 15;

  // A write strobe outranks a read strobe when the CPU raises both.
  function automatic op_t decode_op(input logic rd, input logic wr);
    op_t op;
    op = OP_NOP;
    if (wr)      op = OP_WRITE;
    else if (rd) op = OP_READ;
    return op;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/x86_sram_bridge.sv
// Serves x86cpu byte reads/writes from a 16-bit asynchronous SRAM with a fixed
// number of access cycles, and pulses `locked` once per completed bus cycle.
module x86_sram_bridge
  import x86_sram_bridge_pkg::*;
#(
  parameter int WAIT    = 2,
  parameter int SRAM_AW = 18
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [19:0]        address,
  input  logic [7:0]         o_data,
  input  logic               rd,
  input  logic               wr,
  output logic [7:0]         i_data,
  output logic               locked,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [15:0]        sram_din,
  output logic [15:0]        sram_dout,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_lb_n,
  output logic               sram_ub_n
);

  if (WAIT < WAIT_MIN || WAIT > WAIT_MAX) begin : g_wait_check
    $error("x86_sram_bridge: WAIT=%0d is outside 1..15", WAIT);
  end
  if (SRAM_AW < 1 || SRAM_AW > 19) begin : g_aw_check
    $error("x86_sram_bridge: SRAM_AW=%0d is outside 1..19", SRAM_AW);
  end

  localparam logic [3:0] CNT_LOAD = 4'(WAIT - 1);

  bst_t               state, state_nxt;
  op_t                op_q, req_op, nxt_op;
  logic               lane_q, nxt_lane;
  logic [3:0]         cnt_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [15:0]        dout_q;
  logic               dq_q;
  logic [7:0]         rdata_q;
  logic [19:0]        hi_bits;
  logic               in_range, start, setup_rw, setup_wr;
  logic               locked_q, ce_n_q, oe_n_q, we_n_q, lb_n_q, ub_n_q;
  logic               locked_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt, lb_n_nxt, ub_n_nxt;

  assign req_op   = decode_op(rd, wr);
  assign hi_bits  = address >> (SRAM_AW + 1);
  assign in_range = (hi_bits == '0);
  assign start    = (req_op != OP_NOP) && in_range;

  always_comb begin
    state_nxt  = state;
    nxt_op     = op_q;
    nxt_lane   = lane_q;
    locked_nxt = 1'b0;
    ce_n_nxt   = 1'b1;
    oe_n_nxt   = 1'b1;
    we_n_nxt   = 1'b1;
    lb_n_nxt   = 1'b1;
    ub_n_nxt   = 1'b1;
    case (state)
      BST_IDLE: begin
        nxt_op    = req_op;
        nxt_lane  = address[0];
        state_nxt = start ? BST_ACCESS : BST_DONE;
      end
      BST_ACCESS: if (cnt_q == '0) state_nxt = BST_DONE;
      BST_DONE:   state_nxt = BST_IDLE;
      default:    state_nxt = BST_IDLE;
    endcase
    // Strobes are registered from the next state so the SRAM pins never glitch.
    if (state_nxt == BST_ACCESS) begin
      ce_n_nxt = 1'b0;
      we_n_nxt = (nxt_op != OP_WRITE);
      oe_n_nxt = (nxt_op != OP_READ);
      lb_n_nxt = nxt_lane;
      ub_n_nxt = !nxt_lane;
    end
    locked_nxt = (state_nxt == BST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= BST_IDLE;
      op_q     <= OP_NOP;
      lane_q   <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      dout_q   <= '0;
      dq_q     <= 1'b0;
      rdata_q  <= OOR_READ_VAL;
      locked_q <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
    end else begin
      state    <= state_nxt;
      locked_q <= locked_nxt;
      ce_n_q   <= ce_n_nxt;
      oe_n_q   <= oe_n_nxt;
      we_n_q   <= we_n_nxt;
      lb_n_q   <= lb_n_nxt;
      ub_n_q   <= ub_n_nxt;
      case (state)
        BST_IDLE: begin
          op_q <= req_op;
          if (start) begin
            addr_q <= address[SRAM_AW:1];
            lane_q <= address[0];
            cnt_q  <= CNT_LOAD;
            dq_q   <= (req_op == OP_WRITE);
            if (req_op == OP_WRITE) dout_q <= {o_data, o_data};
          end else if (req_op == OP_READ) begin
            rdata_q <= OOR_READ_VAL;
          end
        end
        BST_ACCESS: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 4'd1;
          if (cnt_q == '0 && op_q == OP_READ) rdata_q <= lane_byte(sram_din, lane_q);
        end
        BST_DONE: dq_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // During the request cycle the pins already follow the CPU bus, giving the
  // SRAM one cycle of address/data setup before we_n falls.
  assign setup_rw = (state == BST_IDLE) && start;
  assign setup_wr = setup_rw && (req_op == OP_WRITE);

  assign sram_addr  = setup_rw ? address[SRAM_AW:1] : addr_q;
  assign sram_dout  = setup_wr ? {o_data, o_data} : dout_q;
  assign sram_dq_oe = setup_wr | dq_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_lb_n  = lb_n_q;
  assign sram_ub_n  = ub_n_q;
  assign locked     = locked_q;
  assign i_data     = rdata_q;

endmodule

// File: tb/tb_x86_sram_bridge.sv
// Directed bench for x86_sram_bridge: one WAIT=2 instance with a byte-lane SRAM
// model, plus WAIT=1/2/15 instances exercised by a locked-driven CPU model.
module tb_x86_sram_bridge;

  logic clock = 1'b0;
  always #40 clock = ~clock;

  logic        reset;
  logic [19:0] address;
  logic [7:0]  o_data, i_data;
  logic        rd, wr, locked;
  logic [17:0] sram_addr;
  logic [15:0] sram_din, sram_dout;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  int errors = 0;
  int checks = 0;

  x86_sram_bridge #(.WAIT(2), .SRAM_AW(18)) dut (
    .clock(clock), .reset(reset), .address(address), .o_data(o_data),
    .rd(rd), .wr(wr), .i_data(i_data), .locked(locked),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  logic [15:0] mem [256];
  always_comb sram_din = mem[sram_addr[7:0]];

  always @(posedge clock) begin
    if (reset) begin
      mem[8'h00] <= 16'hA55A;
      mem[8'h01] <= 16'hBEEF;
      mem[8'h02] <= 16'h0000;
      mem[8'h80] <= 16'h1234;
    end else if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dout[7:0];
      if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dout[15:8];
    end
  end

  int we_low = 0;
  int ce_low = 0;
  always @(negedge clock) begin
    if (!sram_we_n) we_low <= we_low + 1;
    if (!sram_ce_n) ce_low <= ce_low + 1;
  end

  localparam int NX = 3;
  logic [19:0] x_address [NX];
  logic [7:0]  x_odata   [NX];
  logic        x_rd      [NX];
  logic        x_wr      [NX];
  logic [7:0]  x_idata   [NX];
  logic        x_locked  [NX];
  logic [17:0] x_saddr   [NX];
  logic [15:0] x_sdin    [NX];
  logic [15:0] x_sdout   [NX];
  logic        x_dqoe    [NX];
  logic        x_ce_n    [NX];
  logic        x_oe_n    [NX];
  logic        x_we_n    [NX];
  logic        x_lb_n    [NX];
  logic        x_ub_n    [NX];

  always_comb
    for (int j = 0; j < NX; j++) x_sdin[j] = {~x_saddr[j][7:0], x_saddr[j][7:0]};

  for (genvar g = 0; g < NX; g++) begin : gx
    x86_sram_bridge #(.WAIT(g == 0 ? 1 : (g == 1 ? 2 : 15)), .SRAM_AW(18)) u_x (
      .clock(clock), .reset(reset), .address(x_address[g]), .o_data(x_odata[g]),
      .rd(x_rd[g]), .wr(x_wr[g]), .i_data(x_idata[g]), .locked(x_locked[g]),
      .sram_addr(x_saddr[g]), .sram_din(x_sdin[g]), .sram_dout(x_sdout[g]),
      .sram_dq_oe(x_dqoe[g]), .sram_ce_n(x_ce_n[g]), .sram_oe_n(x_oe_n[g]),
      .sram_we_n(x_we_n[g]), .sram_lb_n(x_lb_n[g]), .sram_ub_n(x_ub_n[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered just after the edge that closes a locked cycle (bridge in IDLE).
  task automatic do_req(input string tag, input logic r, input logic w,
                        input logic [19:0] a, input logic [7:0] d, input int exp_lat);
    int n;
    address = a; o_data = d; rd = r; wr = w; n = 0;
    do begin
      @(posedge clock); #1; n++;
    end while (locked !== 1'b1 && n < 40);
    check({tag, "_latency"}, n, exp_lat);
    @(posedge clock); #1;
    check({tag, "_single_pulse"}, locked, 1'b0);
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic run_b2b(input int k, input int w);
    int n;
    logic [19:0] a;
    logic [7:0]  wa, exp;
    n = 0;
    while (x_locked[k] !== 1'b1 && n < 64) begin
      @(posedge clock); #1; n++;
    end
    check($sformatf("b2b%0d_sync", w), x_locked[k], 1'b1);
    @(posedge clock); #1;
    for (int i = 0; i < 8; i++) begin
      a = 20'h00010 + 20'(i * 3);
      wa = a[8:1];
      exp = a[0] ? ~wa : wa;
      x_address[k] = a; x_rd[k] = 1'b1; n = 0;
      do begin
        @(posedge clock); #1; n++;
      end while (x_locked[k] !== 1'b1 && n < 40);
      check($sformatf("b2b%0d_spacing_%0d", w, i), n + 1, w + 2);
      check($sformatf("b2b%0d_data_%0d", w, i), x_idata[k], exp);
      @(posedge clock); #1;
      check($sformatf("b2b%0d_gap_%0d", w, i), x_locked[k], 1'b0);
    end
    x_rd[k] = 1'b0;
  endtask

  initial begin
    int w0, c0;
    reset = 1'b1; address = '0; o_data = '0; rd = 1'b0; wr = 1'b0;
    for (int j = 0; j < NX; j++) begin
      x_address[j] = '0; x_odata[j] = '0; x_rd[j] = 1'b0; x_wr[j] = 1'b0;
    end
    repeat (2) @(posedge clock);
    #1;
    check("rst_locked", locked, 1'b0);
    check("rst_i_data", i_data, 8'hFF);
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 5'b11111);
    check("rst_dq_oe", sram_dq_oe, 1'b0);
    check("rst_sram_addr", sram_addr, 18'h0);
    check("rst_sram_dout", sram_dout, 16'h0);
    reset = 1'b0;

    do_req("rd_lo", 1'b1, 1'b0, 20'h00000, 8'h00, 3);
    check("rd_lo_data", i_data, 8'h5A);
    do_req("rd_hi", 1'b1, 1'b0, 20'h00001, 8'h00, 3);
    check("rd_hi_data", i_data, 8'hA5);

    w0 = we_low;
    address = 20'h00101; o_data = 8'h3C; wr = 1'b1;
    @(negedge clock);
    check("wr_setup_addr", sram_addr, 18'h00080);
    check("wr_setup_dout", sram_dout, 16'h3C3C);
    check("wr_setup_oe", sram_dq_oe, 1'b1);
    check("wr_setup_we", sram_we_n, 1'b1);
    @(posedge clock); #1;
    check("wr_acc_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 5'b01010);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("wr_done_locked", locked, 1'b1);
    check("wr_done_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    check("wr_hold_addr", sram_addr, 18'h00080);
    check("wr_hold_dout", sram_dout, 16'h3C3C);
    check("wr_hold_oe", sram_dq_oe, 1'b1);
    check("wr_we_cycles", we_low - w0, 2);
    @(posedge clock); #1;
    wr = 1'b0;
    check("wr_single_pulse", locked, 1'b0);
    check("wr_mem", mem[8'h80], 16'h3C34);
    check("wr_i_data_kept", i_data, 8'hA5);

    c0 = ce_low;
    do_req("oor_rd", 1'b1, 1'b0, 20'hF0000, 8'h00, 1);
    check("oor_rd_data", i_data, 8'hFF);
    check("oor_rd_no_ce", ce_low - c0, 0);
    w0 = we_low;
    do_req("oor_wr", 1'b0, 1'b1, 20'hF0000, 8'h99, 1);
    check("oor_wr_no_we", we_low - w0, 0);
    check("oor_wr_dq_oe", sram_dq_oe, 1'b0);

    w0 = we_low;
    do_req("rdwr", 1'b1, 1'b1, 20'h00002, 8'h11, 3);
    check("rdwr_mem", mem[8'h01], 16'hBE11);
    check("rdwr_we_cycles", we_low - w0, 2);
    check("rdwr_i_data_kept", i_data, 8'hFF);

    address = 20'h00004; o_data = 8'h77; wr = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("abort_we_active", sram_we_n, 1'b0);
    reset = 1'b1; wr = 1'b0; address = '0;
    @(posedge clock); #1;
    check("abort_we_n", sram_we_n, 1'b1);
    check("abort_locked", locked, 1'b0);
    check("abort_strobes", {sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n}, 4'b1111);
    check("abort_dq_oe", sram_dq_oe, 1'b0);
    check("abort_sram_addr", sram_addr, 18'h0);
    check("abort_sram_dout", sram_dout, 16'h0);
    check("abort_i_data", i_data, 8'hFF);
    reset = 1'b0;
    do_req("post_rst", 1'b1, 1'b0, 20'h00000, 8'h00, 3);
    check("post_rst_data", i_data, 8'h5A);

    run_b2b(0, 1);
    run_b2b(1, 2);
    run_b2b(2, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
